// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline with a one-entry multdiv scoreboard.
// Detects load-use hazards, stalls only instructions that read or overwrite
// the pending multdiv destination (or would need the busy multdiv), launches
// the non-blocking multdiv and signals its write-back cycle.
module hazard_scoreboard #(
    parameter bit USE_READY    = 1'b1,
    parameter int MDIV_LATENCY = 17,
    parameter int CNT_W        = 8,
    parameter int STALL_CNT_W  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            fd_ir,
    input  logic [31:0]            dx_ir,
    input  logic                   flush,
    input  logic                   mdiv_ready,
    output logic                   stall_sel,
    output logic [1:0]             stall_cause,
    output logic                   mdiv_start,
    output logic                   mdiv_busy,
    output logic [4:0]             mdiv_rd,
    output logic                   mdiv_wb_en,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    logic                   r_busy;
    logic [4:0]             r_mdiv_rd;
    logic [CNT_W-1:0]       r_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    // F/D field extraction and decode
    logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt, w_fd_alu;
    logic [4:0] w_dx_op, w_dx_rd, w_dx_alu;
    logic       w_fd_r, w_fd_md, w_fd_sw, w_fd_writes;
    logic       w_fd_uses_rs, w_fd_uses_rt, w_fd_uses_rd;
    logic       w_dx_lw, w_dx_md;
    logic       w_unused_bits;

    assign w_fd_op  = fd_ir[31:27];
    assign w_fd_rd  = fd_ir[26:22];
    assign w_fd_rs  = fd_ir[21:17];
    assign w_fd_rt  = fd_ir[16:12];
    assign w_fd_alu = fd_ir[6:2];
    assign w_dx_op  = dx_ir[31:27];
    assign w_dx_rd  = dx_ir[26:22];
    assign w_dx_alu = dx_ir[6:2];

    // shamt, low bits and the D/X source fields play no part in hazards here
    assign w_unused_bits = ^{fd_ir[11:7], fd_ir[1:0], dx_ir[21:7], dx_ir[1:0]};

    assign w_fd_r       = (w_fd_op == OP_R);
    assign w_fd_md      = w_fd_r & ((w_fd_alu == ALU_MUL) | (w_fd_alu == ALU_DIV));
    assign w_fd_sw      = (w_fd_op == OP_SW);
    assign w_fd_writes  = w_fd_r | (w_fd_op == OP_ADDI) | (w_fd_op == OP_LW);
    assign w_fd_uses_rs = w_fd_r | (w_fd_op == OP_ADDI) | (w_fd_op == OP_LW) | w_fd_sw
                        | (w_fd_op == OP_BNE) | (w_fd_op == OP_BLT);
    assign w_fd_uses_rt = w_fd_r;
    assign w_fd_uses_rd = w_fd_sw | (w_fd_op == OP_BNE) | (w_fd_op == OP_BLT)
                        | (w_fd_op == OP_JR);

    assign w_dx_lw = (w_dx_op == OP_LW);
    assign w_dx_md = (w_dx_op == OP_R) & ((w_dx_alu == ALU_MUL) | (w_dx_alu == ALU_DIV));

    // Hazard terms; register $0 never matches, as source or destination
    logic w_load_use, w_dep, w_struct, w_done;

    // sw store data is forwarded W->M, so it cannot cause a load-use stall
    assign w_load_use = w_dx_lw & (w_dx_rd != 5'd0) &
                        ((w_fd_uses_rs & (w_fd_rs == w_dx_rd)) |
                         (w_fd_uses_rt & (w_fd_rt == w_dx_rd)) |
                         (w_fd_uses_rd & ~w_fd_sw & (w_fd_rd == w_dx_rd)));

    assign w_dep = r_busy & (r_mdiv_rd != 5'd0) &
                   ((w_fd_uses_rs & (w_fd_rs == r_mdiv_rd)) |
                    (w_fd_uses_rt & (w_fd_rt == r_mdiv_rd)) |
                    (w_fd_uses_rd & (w_fd_rd == r_mdiv_rd)));

    // Second term is WAW: an older multdiv result must not overwrite a younger write
    assign w_struct = (w_fd_md & (r_busy | w_dx_md)) |
                      (r_busy & w_fd_writes & (r_mdiv_rd != 5'd0) & (w_fd_rd == r_mdiv_rd));

    assign w_done = USE_READY ? (r_busy & mdiv_ready) : (r_busy & (r_cnt == '0));

    // Combinational outputs are forced low while reset is held
    always_comb begin
        stall_sel   = 1'b0;
        stall_cause = 2'b00;
        mdiv_start  = 1'b0;
        if (!reset) begin
            stall_sel  = w_load_use | w_dep | w_struct;
            mdiv_start = w_dx_md & ~flush & ~r_busy;
            if (w_struct)        stall_cause = 2'b11;
            else if (w_dep)      stall_cause = 2'b10;
            else if (w_load_use) stall_cause = 2'b01;
        end
    end

    // Scoreboard entry: issue, fixed-latency countdown, release after done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_mdiv_rd <= 5'd0;
            r_cnt     <= '0;
        end else if (mdiv_start) begin
            r_busy    <= 1'b1;
            r_mdiv_rd <= w_dx_rd;
            if (!USE_READY) r_cnt <= CNT_W'(MDIV_LATENCY - 1);
        end else if (w_done) begin
            r_busy <= 1'b0;
        end else if (r_busy && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (stall_sel && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign mdiv_busy    = r_busy;
    assign mdiv_rd      = r_mdiv_rd;
    assign mdiv_wb_en   = w_done;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [31:0] NOP    = 32'd0;

    typedef struct {
        int          sel;
        logic        stall;
        logic [1:0]  cause;
        logic        start;
        logic        busy;
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] sc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] fd_v  [3];
    logic [31:0] dx_v  [3];
    logic        fl_v  [3];
    logic        rdy_v [3];
    logic        rst_v [3];

    logic        st_o  [3];
    logic [1:0]  ca_o  [3];
    logic        sta_o [3];
    logic        bsy_o [3];
    logic [4:0]  rd_o  [3];
    logic        wb_o  [3];
    logic [31:0] sc_o  [3];

    exp_t        q[$];
    exp_t        e;
    int unsigned exp_sc [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    // 0: fixed latency 4, 1: ready-driven completion, 2: fixed latency 1
    hazard_scoreboard #(.USE_READY(1'b0), .MDIV_LATENCY(4), .CNT_W(8), .STALL_CNT_W(32)) u_lat4 (
        .clock(clk), .reset(rst_v[0]), .fd_ir(fd_v[0]), .dx_ir(dx_v[0]), .flush(fl_v[0]),
        .mdiv_ready(rdy_v[0]), .stall_sel(st_o[0]), .stall_cause(ca_o[0]), .mdiv_start(sta_o[0]),
        .mdiv_busy(bsy_o[0]), .mdiv_rd(rd_o[0]), .mdiv_wb_en(wb_o[0]), .stall_cycles(sc_o[0]));

    hazard_scoreboard #(.USE_READY(1'b1), .MDIV_LATENCY(17), .CNT_W(8), .STALL_CNT_W(32)) u_rdy (
        .clock(clk), .reset(rst_v[1]), .fd_ir(fd_v[1]), .dx_ir(dx_v[1]), .flush(fl_v[1]),
        .mdiv_ready(rdy_v[1]), .stall_sel(st_o[1]), .stall_cause(ca_o[1]), .mdiv_start(sta_o[1]),
        .mdiv_busy(bsy_o[1]), .mdiv_rd(rd_o[1]), .mdiv_wb_en(wb_o[1]), .stall_cycles(sc_o[1]));

    hazard_scoreboard #(.USE_READY(1'b0), .MDIV_LATENCY(1), .CNT_W(8), .STALL_CNT_W(32)) u_lat1 (
        .clock(clk), .reset(rst_v[2]), .fd_ir(fd_v[2]), .dx_ir(dx_v[2]), .flush(fl_v[2]),
        .mdiv_ready(rdy_v[2]), .stall_sel(st_o[2]), .stall_cause(ca_o[2]), .mdiv_start(sta_o[2]),
        .mdiv_busy(bsy_o[2]), .mdiv_rd(rd_o[2]), .mdiv_wb_en(wb_o[2]), .stall_cycles(sc_o[2]));

    function automatic logic [31:0] r_ins(input int rd, input int rs, input int rt, input int alu);
        r_ins = {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'b00000, 5'(alu), 2'b00};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] op, input int rd, input int rs);
        i_ins = {op, 5'(rd), 5'(rs), 17'd0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every sampled cycle pops one expectation and compares the DUT it names
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({e.name, ".stall_sel"},    32'(st_o[e.sel]),  32'(e.stall));
            chk({e.name, ".stall_cause"},  32'(ca_o[e.sel]),  32'(e.cause));
            chk({e.name, ".mdiv_start"},   32'(sta_o[e.sel]), 32'(e.start));
            chk({e.name, ".mdiv_busy"},    32'(bsy_o[e.sel]), 32'(e.busy));
            chk({e.name, ".mdiv_rd"},      32'(rd_o[e.sel]),  32'(e.rd));
            chk({e.name, ".mdiv_wb_en"},   32'(wb_o[e.sel]),  32'(e.wb));
            chk({e.name, ".stall_cycles"}, sc_o[e.sel],       e.sc);
        end
    end

    // One cycle of stimulus to DUT s (others see nops); expectation is queued for the monitor
    task automatic step(input int s, input logic rst_i, input logic [31:0] f, input logic [31:0] d,
                        input logic fl_i, input logic rdy_i,
                        input logic e_st, input logic [1:0] e_c, input logic e_start,
                        input logic e_busy, input int e_rd, input logic e_wb, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            fd_v[i] = NOP; dx_v[i] = NOP; fl_v[i] = 1'b0; rdy_v[i] = 1'b0; rst_v[i] = 1'b0;
        end
        fd_v[s] = f; dx_v[s] = d; fl_v[s] = fl_i; rdy_v[s] = rdy_i; rst_v[s] = rst_i;
        if (rst_i) exp_sc[s] = 0;
        x.sel = s; x.stall = e_st; x.cause = e_c; x.start = e_start; x.busy = e_busy;
        x.rd = 5'(e_rd); x.wb = e_wb; x.sc = exp_sc[s]; x.name = nm;
        q.push_back(x);
        if (e_st) exp_sc[s]++;
    endtask

    initial begin
        logic [31:0] lw3, add_dep3, mul5, add_dep5;
        lw3      = i_ins(OP_LW, 3, 1);
        add_dep3 = r_ins(4, 3, 2, 0);
        mul5     = r_ins(5, 1, 2, 6);
        add_dep5 = r_ins(6, 5, 1, 0);
        for (int i = 0; i < 3; i++) begin
            fd_v[i] = NOP; dx_v[i] = NOP; fl_v[i] = 1'b0; rdy_v[i] = 1'b0; rst_v[i] = 1'b1;
            exp_sc[i] = 0;
        end

        // ---- DUT 0: fixed latency 4 ----
        step(0, 1, add_dep3, lw3, 0, 0,  0, 2'b00, 0, 0, 0, 0, "in_reset");
        step(0, 0, add_dep3, lw3, 0, 0,  1, 2'b01, 0, 0, 0, 0, "load_use");
        step(0, 0, add_dep3, NOP, 0, 0,  0, 2'b00, 0, 0, 0, 0, "load_use_rel");
        step(0, 0, i_ins(OP_SW, 3, 5), lw3, 0, 0,  0, 2'b00, 0, 0, 0, 0, "lu_sw_data");
        step(0, 0, r_ins(4, 0, 2, 0), i_ins(OP_LW, 0, 1), 0, 0,  0, 2'b00, 0, 0, 0, 0, "lu_r0");
        step(0, 0, r_ins(7, 1, 2, 0), mul5, 0, 0,  0, 2'b00, 1, 0, 0, 0, "mul_issue");
        step(0, 0, r_ins(8, 1, 2, 0), r_ins(7, 1, 2, 0), 0, 0,  0, 2'b00, 0, 1, 5, 0, "indep_flow");
        step(0, 0, add_dep5, r_ins(8, 1, 2, 0), 0, 0,  1, 2'b10, 0, 1, 5, 0, "dep_c2");
        step(0, 0, add_dep5, NOP, 0, 0,  1, 2'b10, 0, 1, 5, 0, "dep_c3");
        step(0, 0, add_dep5, NOP, 0, 0,  1, 2'b10, 0, 1, 5, 1, "dep_done");
        step(0, 0, add_dep5, NOP, 0, 0,  0, 2'b00, 0, 0, 5, 0, "dep_release");
        step(0, 0, r_ins(9, 1, 2, 7), mul5, 0, 0,  1, 2'b11, 1, 0, 5, 0, "struct_dx_md");
        step(0, 0, r_ins(9, 1, 2, 7), NOP, 0, 0,  1, 2'b11, 0, 1, 5, 0, "struct_busy");
        step(0, 0, i_ins(OP_ADDI, 5, 0), NOP, 1, 0,  1, 2'b11, 0, 1, 5, 0, "waw_flush");
        step(0, 0, r_ins(5, 5, 1, 0), NOP, 0, 0,  1, 2'b11, 0, 1, 5, 0, "waw_over_dep");
        step(0, 0, i_ins(OP_SW, 5, 1), NOP, 0, 0,  1, 2'b10, 0, 1, 5, 1, "sw_dep_done");
        step(0, 0, i_ins(OP_SW, 5, 1), NOP, 0, 0,  0, 2'b00, 0, 0, 5, 0, "sw_release");
        step(0, 0, NOP, mul5, 1, 0,  0, 2'b00, 0, 0, 5, 0, "flush_md");
        step(0, 0, NOP, NOP, 0, 0,  0, 2'b00, 0, 0, 5, 0, "flush_no_issue");
        step(0, 0, i_ins(OP_BNE, 3, 1), lw3, 0, 0,  1, 2'b01, 0, 0, 5, 0, "lu_bne_rd");
        step(0, 0, i_ins(OP_BNE, 3, 1), NOP, 0, 0,  0, 2'b00, 0, 0, 5, 0, "lu_bne_rel");
        step(0, 0, NOP, r_ins(11, 1, 2, 6), 0, 0,  0, 2'b00, 1, 0, 5, 0, "mul11_issue");
        step(0, 0, NOP, NOP, 0, 0,  0, 2'b00, 0, 1, 11, 0, "mul11_busy");
        step(0, 1, NOP, NOP, 0, 0,  0, 2'b00, 0, 0, 0, 0, "async_reset");
        for (int i = 0; i < 4; i++)
            step(0, 0, NOP, NOP, 0, 0,  0, 2'b00, 0, 0, 0, 0, "post_reset");

        // ---- DUT 1: completion from mdiv_ready ----
        step(1, 0, NOP, NOP, 0, 1,  0, 2'b00, 0, 0, 0, 0, "rdy_idle");
        step(1, 0, NOP, r_ins(12, 1, 2, 6), 0, 0,  0, 2'b00, 1, 0, 0, 0, "rdy_issue");
        for (int i = 0; i < 6; i++)
            step(1, 0, NOP, NOP, 0, 0,  0, 2'b00, 0, 1, 12, 0, "rdy_wait");
        step(1, 0, NOP, NOP, 0, 1,  0, 2'b00, 0, 1, 12, 1, "rdy_done");
        step(1, 0, NOP, NOP, 0, 0,  0, 2'b00, 0, 0, 12, 0, "rdy_release");
        step(1, 0, NOP, NOP, 0, 1,  0, 2'b00, 0, 0, 12, 0, "rdy_idle2");
        step(1, 0, NOP, r_ins(13, 1, 2, 6), 1, 0,  0, 2'b00, 0, 0, 12, 0, "rdy_flush_md");
        step(1, 0, NOP, NOP, 0, 0,  0, 2'b00, 0, 0, 12, 0, "rdy_flush_idle");

        // ---- DUT 2: fixed latency 1 ----
        step(2, 0, NOP, r_ins(14, 1, 2, 7), 0, 0,  0, 2'b00, 1, 0, 0, 0, "lat1_issue");
        step(2, 0, r_ins(15, 14, 0, 0), NOP, 0, 0,  1, 2'b10, 0, 1, 14, 1, "lat1_done");
        step(2, 0, r_ins(15, 14, 0, 0), NOP, 0, 0,  0, 2'b00, 0, 0, 14, 0, "lat1_release");

        // drain: bounded wait for the monitor to consume everything
        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Next-generation hazard unit for the 5-stage pipeline. It replaces blanket stalling on every mult/div with a one-entry scoreboard. The multdiv unit runs non-blocking, and only instructions that depend on its pending destination, or that conflict with it, are held in F/D. It also provides load-use detection, a completion mode selectable by parameter, a stall-cause code and a saturating stall-cycle counter.

Parameters:
USE_READY, 1, 1: completion taken from mdiv_ready; 0: completion from internal fixed-latency counter
MDIV_LATENCY, 17, cycles from issue to completion when USE_READY=0; legal range 1..255
CNT_W, 8, width of internal latency counter; must hold MDIV_LATENCY-1
STALL_CNT_W, 32, width of stall_cycles counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
fd_ir  in  32  instruction in F/D latch
dx_ir  in  32  instruction in D/X latch
flush  in  1  branch/jump taken this cycle; D/X contents are squashed
mdiv_ready  in  1  multdiv result valid (used only when USE_READY=1)
stall_sel  out  1  hold PC and F/D, insert nop into D/X
stall_cause  out  2  00 none, 01 load-use, 10 mdiv data dependency, 11 mdiv structural/WAW
mdiv_start  out  1  one-cycle pulse: launch multdiv with D/X operands
mdiv_busy  out  1  scoreboard entry valid
mdiv_rd  out  5  pending destination tag
mdiv_wb_en  out  1  completion cycle: write multdiv result to mdiv_rd
stall_cycles  out  STALL_CNT_W  count of cycles with stall_sel=1

Behaviour:
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
- Classes: R = 00000; mult = R & aluop 00110; div = R & aluop 00111; md = mult|div; addi 00101; lw 01000; sw 00111; bne 00010; blt 00110; jr 00100.
- FD sources: rs for R/addi/lw/sw/bne/blt; rt for R only; rd for sw/bne/blt/jr.
- FD writes rd for R/addi/lw.
- Register 0 never matches any comparison, as source or as destination.
- load_use (combinational) = dx is lw & dx_rd≠0 & dx_rd equals an fd source. The sw data source (fd rd) is excluded because it is bypassed at W→M.
- dep = busy & mdiv_rd≠0 & mdiv_rd equals an fd source.
- struct = (fd is md & (busy | dx is md)) | (busy & fd writes rd = mdiv_rd ≠ 0), the second term being the WAW case.
- stall_sel = load_use | dep | struct.
- stall_cause priority: 11 > 10 > 01 > 00.
- The struct rule guarantees dx md never meets busy=1.
- mdiv_start = dx is md & ~flush & ~busy. It is combinational and asserts in the same cycle.
- On the clock edge where mdiv_start=1: busy←1, mdiv_rd←dx_rd. If USE_READY=0, also cnt←MDIV_LATENCY-1.
- Completion (combinational):
  - USE_READY=1: done = busy & mdiv_ready. mdiv_ready while idle is ignored.
  - USE_READY=0: done = busy & cnt==0. While busy and cnt≠0, cnt decrements each cycle.
  - mdiv_wb_en = done.
  - On the edge after done, busy←0. mdiv_rd holds its value until the next issue.
- Timing: dep/struct stay asserted in the done cycle and release the following cycle, when the result is in the regfile.
- MDIV_LATENCY=1: done is asserted in the cycle after issue.
- flush in the same cycle as dx md: no issue and no state change. flush while busy does not cancel the in-flight op, because it is older than the branch.
- Issue and done never coincide, because busy=0 at issue.
- stall_cycles increments on every edge where stall_sel=1 and saturates at all-ones.
- Reset values: busy=0, mdiv_rd=0, cnt=0, stall_cycles=0. All outputs are 0 during and immediately after reset.
- Reset mid-operation abandons the op. No mdiv_wb_en is generated afterwards, even if mdiv_ready later pulses.

Test Plan:
- Load-use: dx=lw $3,0($1), fd=add $4,$3,$2 → stall_sel=1, cause=01, one cycle. With fd=sw $3,0($5) → stall_sel=0. With dx lw to $0 → no stall.
- Non-blocking mult, USE_READY=0, LAT=4: dx=mul $5,$1,$2 → mdiv_start=1. Independent adds flow with stall_sel=0. mdiv_wb_en=1 exactly 4 cycles after the start cycle, with mdiv_rd=5. busy drops one cycle later.
- Dependency: fd=add $6,$5,$1 issued one cycle after the mul to $5 → stall_sel=1, cause=10, until the cycle after mdiv_wb_en. stall_cycles equals the number of stalled cycles.
- Structural/WAW: fd=div while busy → cause=11. fd=addi $5,$0,1 while pending $5 → cause=11. fd=mul while dx=mul → cause=11.
- USE_READY=1: pulse mdiv_ready while idle → no wb_en. Issue, then ready after 7 cycles → wb_en in that cycle. flush with dx=mul → mdiv_start=0, busy stays 0.
- Reset asserted while busy with cnt=2 → busy=0, mdiv_rd=0 and stall_cycles=0 immediately (asynchronous). No wb_en follows.
